// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a DEPTH-entry circular buffer of fetched PC/instruction
// pairs feeding a registered output stage, with optional empty-queue bypass.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [DATA_W-1:0]            if_inst,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [5:0]                   stall,
  input  logic                         flush,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [DATA_W-1:0]            id_inst,
  output logic                         id_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam int  STALL_IF = 1;
  localparam int  STALL_ID = 2;
  localparam logic STOP    = 1'b1;
  localparam logic FLUSH   = 1'b1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [ADDR_W-1:0] id_pc_q,  id_pc_d;
  logic [DATA_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  logic push, adv, pop, bypass, write;

  // Only the IF and ID stop bits of the ctrl pause vector concern this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign if_ready = (count_q != CNT_W'(DEPTH));
  assign push     = if_valid & if_ready & (stall[STALL_IF] != STOP) & (flush != FLUSH);
  assign adv      = (stall[STALL_ID] != STOP) & (flush != FLUSH);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    pop        = 1'b0;
    bypass     = 1'b0;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (flush == FLUSH) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (adv) begin
        if (count_q != '0) begin
          pop        = 1'b1;
          id_pc_d    = pc_mem[rd_ptr_q];
          id_inst_d  = inst_mem[rd_ptr_q];
          id_valid_d = 1'b1;
        end else if (push && (BYPASS != 0)) begin
          bypass     = 1'b1;
          id_pc_d    = if_pc;
          id_inst_d  = if_inst;
          id_valid_d = 1'b1;
        end else begin
          id_pc_d    = '0;
          id_inst_d  = '0;
          id_valid_d = 1'b0;
        end
      end
      // Pointer widths equal log2(DEPTH), so the increment wraps on its own.
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(write);
      count_d  = count_q + CNT_W'(write) - CNT_W'(pop);
    end
  end

  assign write = push & ~bypass;

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (write) begin
      pc_mem[wr_ptr_q]   <= if_pc;
      inst_mem[wr_ptr_q] <= if_inst;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign count    = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a bypass and a non-bypass instance share stimulus and are
// scored each cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_valid = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;

  logic [1:0]        if_ready, id_valid;
  logic [1:0][31:0]  id_pc, id_inst;
  logic [1:0][CW-1:0] count;

  always #5 clk = ~clk;

  if_id_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .if_ready(if_ready[0]), .stall(stall), .flush(flush), .id_pc(id_pc[0]),
    .id_inst(id_inst[0]), .id_valid(id_valid[0]), .count(count[0]));

  if_id_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .if_ready(if_ready[1]), .stall(stall), .flush(flush), .id_pc(id_pc[1]),
    .id_inst(id_inst[1]), .id_valid(id_valid[1]), .count(count[1]));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct packed {
    logic [1:0][31:0]   pc;
    logic [1:0][31:0]   inst;
    logic [1:0]         v;
    logic [1:0][CW-1:0] cnt;
    logic [1:0]         rdy;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: one instruction queue plus the visible ID-stage value per instance.
  ent_t mq[2][$];
  ent_t mo[2];
  logic mv[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input int b, input bit byp, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [5:0] st, input logic fl);
    bit push, used;
    if (fl) begin
      mq[b].delete();
      mo[b] = '0;
      mv[b] = 1'b0;
    end else begin
      push = v && (mq[b].size() != DEPTH) && !st[1];
      used = 1'b0;
      if (!st[2]) begin
        if (mq[b].size() > 0) begin
          mo[b] = mq[b].pop_front();
          mv[b] = 1'b1;
        end else if (push && byp) begin
          mo[b] = '{pc: pc, inst: inst};
          mv[b] = 1'b1;
          used  = 1'b1;
        end else begin
          mo[b] = '0;
          mv[b] = 1'b0;
        end
      end
      if (push && !used) mq[b].push_back('{pc: pc, inst: inst});
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      mq[b].delete();
      mo[b] = '0;
      mv[b] = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge state.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [5:0] st, input logic fl);
    exp_t e;
    @(negedge clk);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    stall    = st;
    flush    = fl;
    for (int b = 0; b < 2; b++) begin
      model_step(b, (b == 1), v, pc, inst, st, fl);
      e.pc[b]   = mo[b].pc;
      e.inst[b] = mo[b].inst;
      e.v[b]    = mv[b];
      e.cnt[b]  = CW'(mq[b].size());
      e.rdy[b]  = (mq[b].size() != DEPTH);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 6'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int b = 0; b < 2; b++) begin
      check($sformatf("%s_id_valid%0d", tag, b), 64'(id_valid[b]), 64'd0);
      check($sformatf("%s_id_pc%0d", tag, b), 64'(id_pc[b]), 64'd0);
      check($sformatf("%s_id_inst%0d", tag, b), 64'(id_inst[b]), 64'd0);
      check($sformatf("%s_count%0d", tag, b), 64'(count[b]), 64'd0);
      check($sformatf("%s_if_ready%0d", tag, b), 64'(if_ready[b]), 64'd1);
    end
  endtask

  // Monitor: compares the DUTs against each queued expectation just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int b = 0; b < 2; b++) begin
          check($sformatf("id_valid%0d", b), 64'(id_valid[b]), 64'(e.v[b]));
          check($sformatf("id_pc%0d", b), 64'(id_pc[b]), 64'(e.pc[b]));
          check($sformatf("id_inst%0d", b), 64'(id_inst[b]), 64'(e.inst[b]));
          check($sformatf("count%0d", b), 64'(count[b]), 64'(e.cnt[b]));
          check($sformatf("if_ready%0d", b), 64'(if_ready[b]), 64'(e.rdy[b]));
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    int          waited;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b1;

    // Empty-queue latency: one edge with bypass, two without.
    cyc(1'b1, 32'h100, 32'h3C011234, 6'b0, 1'b0);
    idle(3);

    // Fill under ID stall; the fifth push meets a full queue.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(i * 4), $urandom, 6'b000100, 1'b0);
    idle(6);

    // Flush with three queued entries and a same-cycle push.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h180 + 32'(i * 4), $urandom, 6'b000100, 1'b0);
    cyc(1'b1, 32'h200, $urandom, 6'b0, 1'b1);
    idle(3);

    // IF stall on an empty queue leaves the output bubbling.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300, $urandom, 6'b000010, 1'b0);
    idle(2);

    // Streaming with alternating ID stall exercises pointer wrap.
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'h400 + 32'(i * 4), $urandom, (i % 2 != 0) ? 6'b000100 : 6'b0, 1'b0);
    idle(6);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + 32'(i * 4), $urandom, 6'b000100, 1'b0);
    @(negedge clk);
    if_valid = 1'b0;
    stall    = 6'b0;
    check("pre_reset_count1", 64'(count[1]), 64'd3);
    #2 rst = 1'b0;
    #1 check_reset_state("async");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] st;
      r  = $urandom;
      st = 6'($urandom);
      st[1] = ($urandom_range(0, 3) == 0);
      st[2] = ($urandom_range(0, 2) == 0);
      cyc(($urandom_range(0, 3) != 0), r & 32'hFFFF_FFFC, $urandom, st,
          ($urandom_range(0, 39) == 0));
    end
    idle(8);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched instruction/PC pairs in a circular queue and presents the head to the decode stage through a registered output stage.
- Decouples fetch from decode stalls, supports ctrl-driven stall/flush, and has an optional empty-queue bypass for zero-added latency.
- Sits between pc_reg/instruction memory and the id stage.

Parameters:
- ADDR_W, 32, width of PC (matches `Inst_Addr).
- DATA_W, 32, width of instruction word (matches `Inst_Data).
- DEPTH, 4, queue entries; power of 2, ≥2.
- BYPASS, 1, 1 = an empty queue forwards incoming instruction straight to the output stage; 0 = every instruction passes through the queue.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- if_pc  input  ADDR_W  fetched instruction address.
- if_inst  input  DATA_W  fetched instruction.
- if_valid  input  1  if_pc/if_inst valid this cycle.
- if_ready  output  1  queue can accept; combinational, = (count != DEPTH).
- stall  input  6  ctrl pause vector; bit1 = IF stop, bit2 = ID stop (`Stop/`NoStop).
- flush  input  1  exception/branch flush (`Flush).
- id_pc  output  ADDR_W  PC presented to ID.
- id_inst  output  DATA_W  instruction presented to ID.
- id_valid  output  1  id_pc/id_inst hold a real instruction.
- count  output  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (rst=0, async): rd_ptr, wr_ptr, count = 0; id_pc = `No_Addr (0); id_inst = `Zero_Word; id_valid = 0. Takes effect immediately, mid-operation included; queue contents are don't-care.
- push = if_valid & if_ready & (stall[1]==`NoStop) & (flush!=`Flush).
- adv = (stall[2]==`NoStop) & (flush!=`Flush). The output stage loads on an adv edge.
- Flush has highest priority after reset. On the edge, pointers and count clear, the output stage gets 0/0/valid 0, and the same-cycle push is dropped.
- On an adv edge the output stage loads in this priority order:
  - count>0: loads the queue head; rd_ptr+1 (wraps mod DEPTH), id_valid=1.
  - count==0, push, BYPASS=1: loads if_pc/if_inst directly; queue not written; id_valid=1.
  - Otherwise: bubble, id_pc=0, id_inst=0, id_valid=0.
- If not adv and no flush, the output stage holds all three values (ID stall).
- Queue write: on push not consumed by bypass, the entry is written at wr_ptr; wr_ptr+1 wraps mod DEPTH.
- count next = count + write − read, where write = queued push and read = head pop.
  - Simultaneous write and read leave count unchanged.
  - A write while full cannot occur because if_ready=0.
  - A pop while empty cannot occur.
- Latency:
  - BYPASS=1, empty queue: instruction visible on id_* one edge after if_valid.
  - BYPASS=0: two edges.
  - Non-empty queue: strict FIFO order, one instruction per adv edge.
- Full: if_ready=0. A simultaneous pop does not raise if_ready in the same cycle; no pass-through when full.
- Pointers are log2(DEPTH) bits, and count distinguishes full from empty.

Test Plan:
- Reset: assert rst=0 mid-stream with count=3 → id_pc=0, id_inst=0, id_valid=0, count=0, if_ready=1 immediately, without waiting for clk.
- Bypass latency: BYPASS=1, empty, stall=0, if_valid=1, pc=0x100, inst=0x3C011234 → after 1 edge id_pc=0x100, id_valid=1, count=0. Same with BYPASS=0 → bubble after edge 1, instruction after edge 2.
- Fill under ID stall: stall[2]=1, push pcs 0x0,0x4,0x8,0xC,0x10 on consecutive cycles:
  - count=4 after 4 edges; if_ready=0; 0x10 not accepted.
  - Release stall → id_pc sequence 0x0,0x4,0x8,0xC on successive edges.
- Wrap and simultaneous push/pop: DEPTH=4, stream 10 instructions with alternating stall[2] → FIFO order preserved across pointer wrap; count constant on push+pop cycles.
- Flush: count=3, flush=1 with if_valid=1 (pc 0x200) → next edge count=0, id_valid=0, id_pc=0, 0x200 dropped.
- IF stall: stall[1]=1, if_valid=1, queue empty → no push; output bubble (id_valid=0) while stall[2]=0.
